// File: rtl/fetch_unit_if.sv
// ============================================================================
//  fetch_unit_if
//  Memory-side req/ack bus and decode-side instruction bus of the fetch stage.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic [ADDR_W-1:0] pc_out;

    modport master (
        output mem_req, mem_addr, instr, instr_valid, pc_out,
        input  mem_ack, mem_rdata, stall, branch_taken, branch_target
    );

    modport slave (
        input  mem_req, mem_addr, instr, instr_valid, pc_out,
        output mem_ack, mem_rdata, stall, branch_taken, branch_target
    );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
//  fetch_unit
//  Instruction fetch stage: PC, single outstanding memory read, branch redirect.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  wire logic     clk,
    input  wire logic     res,
    fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] pc_out_q;
    logic [DATA_W-1:0] instr_q;
    logic              valid_q;

    assign bus.mem_req     = (state_q == S_FETCH) || (state_q == S_DROP);
    assign bus.mem_addr    = addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc_out      = pc_out_q;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            pc_out_q <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    addr_q  <= pc_q;
                    state_q <= S_FETCH;
                end

                S_FETCH: begin
                    if (bus.branch_taken) begin
                        pc_q    <= bus.branch_target;
                        valid_q <= 1'b0;
                        if (bus.mem_ack) begin
                            addr_q  <= bus.branch_target;
                            state_q <= S_FETCH;
                        end else begin
                            // Request still in flight: keep the address until it completes.
                            state_q <= S_DROP;
                        end
                    end else if (bus.mem_ack) begin
                        instr_q  <= bus.mem_rdata;
                        pc_out_q <= addr_q;
                        valid_q  <= 1'b1;
                        pc_q     <= pc_q + 1'b1;
                        state_q  <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (bus.branch_taken) begin
                        pc_q    <= bus.branch_target;
                        addr_q  <= bus.branch_target;
                        valid_q <= 1'b0;
                        state_q <= S_FETCH;
                    end else if (!bus.stall) begin
                        valid_q <= 1'b0;
                        addr_q  <= pc_q;
                        state_q <= S_FETCH;
                    end
                end

                S_DROP: begin
                    if (bus.branch_taken) begin
                        pc_q <= bus.branch_target;
                    end
                    if (bus.mem_ack) begin
                        addr_q  <= bus.branch_taken ? bus.branch_target : pc_q;
                        state_q <= S_FETCH;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
//  tb_fetch_unit
//  Directed plus randomized bench against a request/word-level reference model.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic clk;
    logic res;

    fetch_unit_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    fetch_unit #(.ADDR_W(8), .DATA_W(16), .RESET_PC(8'h00)) dut (
        .clk (clk),
        .res (res),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem [256];

    // Reference model: one outstanding request, an optional held word.
    bit          m_started, m_busy, m_squash, m_valid;
    logic [7:0]  m_pc, m_addr, m_pcout;
    logic [15:0] m_instr;

    logic [7:0]  pcq [$];
    bit          prev_valid;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_started = 0; m_busy = 0; m_squash = 0; m_valid = 0;
        m_pc = 8'h00; m_addr = 8'h00; m_pcout = 8'h00; m_instr = 16'h0000;
        prev_valid = 0;
    endfunction

    function automatic void model_update(input bit ack, input logic [15:0] rdata,
                                         input bit st, input bit br, input logic [7:0] tgt);
        if (!m_started) begin
            m_started = 1; m_busy = 1; m_addr = m_pc;
        end else if (br) begin
            m_pc    = tgt;
            m_valid = 0;
            if (m_busy && !ack) begin
                m_squash = 1;
            end else begin
                m_busy = 1; m_addr = tgt; m_squash = 0;
            end
        end else if (m_busy && ack) begin
            if (m_squash) begin
                m_squash = 0; m_addr = m_pc;
            end else begin
                m_instr = rdata; m_pcout = m_addr; m_valid = 1;
                m_pc = m_pc + 8'd1; m_busy = 0;
            end
        end else if (m_valid && !st) begin
            m_valid = 0; m_busy = 1; m_addr = m_pc;
        end
    endfunction

    task automatic compare_all();
        check_val("mem_req",     bus.mem_req,     m_busy);
        check_val("mem_addr",    bus.mem_addr,    m_addr);
        check_val("instr_valid", bus.instr_valid, m_valid);
        check_val("instr",       bus.instr,       m_instr);
        check_val("pc_out",      bus.pc_out,      m_pcout);
        if (bus.instr_valid && !prev_valid) pcq.push_back(bus.pc_out);
        prev_valid = bus.instr_valid;
    endtask

    // Drive one cycle's inputs, advance the model, check after the edge.
    task automatic step(input bit ack, input bit st, input bit br, input logic [7:0] tgt);
        bus.mem_ack       = ack;
        bus.mem_rdata     = ack ? mem[bus.mem_addr] : 16'($urandom);
        bus.stall         = st;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
        model_update(ack, bus.mem_rdata, st, br, tgt);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        res = 1'b0;
        bus.mem_ack = 0; bus.mem_rdata = '0; bus.stall = 0;
        bus.branch_taken = 0; bus.branch_target = '0;
        for (int a = 0; a < 256; a++) mem[a] = 16'(a) * 16'h0101;
        mem[8'h20] = 16'hF00F;
        model_reset();

        repeat (2) @(negedge clk);
        compare_all();
        res = 1'b1;

        // Free run: first request one cycle after release, words 0000/0101/0202
        pcq.delete();
        step(1, 0, 0, 8'h00);
        check_val("first_req", {bus.mem_req, bus.mem_addr}, {1'b1, 8'h00});
        repeat (8) step(1, 0, 0, 8'h00);
        if (pcq.size() >= 3) begin
            check_val("run_pc0", pcq[0], 8'h00);
            check_val("run_pc1", pcq[1], 8'h01);
            check_val("run_pc2", pcq[2], 8'h02);
        end else check_val("run_pulses", pcq.size(), 3);

        // Branch on the ack cycle: returned word discarded
        step(1, 0, 1, 8'h10);
        check_val("br_ack_valid", bus.instr_valid, 1'b0);
        check_val("br_ack_addr",  bus.mem_addr,    8'h10);
        step(1, 0, 0, 8'h00);
        check_val("br_ack_pc", bus.pc_out, 8'h10);

        // Branch while stalled: word flushed
        step(0, 1, 1, 8'h20);
        check_val("br_stall_valid", bus.instr_valid, 1'b0);
        check_val("br_stall_addr",  bus.mem_addr,    8'h20);

        // Stall holds the word for 4 cycles with no request
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 8'h00);
            check_val("stall_instr", bus.instr,       16'hF00F);
            check_val("stall_pc",    bus.pc_out,      8'h20);
            check_val("stall_valid", bus.instr_valid, 1'b1);
            check_val("stall_noreq", bus.mem_req,     1'b0);
        end
        step(0, 0, 0, 8'h00);
        check_val("post_stall_req", {bus.mem_req, bus.mem_addr}, {1'b1, 8'h21});

        // Branch during outstanding fetch, ack 3 cycles late
        step(0, 0, 1, 8'h40);
        check_val("drop_addr", {bus.mem_req, bus.mem_addr}, {1'b1, 8'h21});
        step(0, 0, 0, 8'h00);
        check_val("drop_hold", bus.mem_addr, 8'h21);
        step(1, 0, 0, 8'h00);
        check_val("drop_novalid", bus.instr_valid, 1'b0);
        check_val("drop_redirect", {bus.mem_req, bus.mem_addr}, {1'b1, 8'h40});
        step(1, 0, 0, 8'h00);
        check_val("drop_pc", {bus.instr_valid, bus.pc_out}, {1'b1, 8'h40});

        // PC wrap
        step(0, 0, 1, 8'hFF);
        pcq.delete();
        repeat (6) step(1, 0, 0, 8'h00);
        if (pcq.size() >= 3) begin
            check_val("wrap_pc0", pcq[0], 8'hFF);
            check_val("wrap_pc1", pcq[1], 8'h00);
            check_val("wrap_pc2", pcq[2], 8'h01);
        end else check_val("wrap_pulses", pcq.size(), 3);

        // Asynchronous reset between edges while a request is pending
        check_val("pre_reset_req", bus.mem_req, 1'b1);
        #2 res = 1'b0;
        #1;
        check_val("areset_req",   bus.mem_req,     1'b0);
        check_val("areset_valid", bus.instr_valid, 1'b0);
        check_val("areset_instr", bus.instr,       16'h0000);
        model_reset();
        bus.mem_ack = 1'b1;
        repeat (2) @(negedge clk);
        res = 1'b1;
        compare_all();
        step(1, 0, 0, 8'h00);
        check_val("restart_req", {bus.mem_req, bus.mem_addr}, {1'b1, 8'h00});

        // Randomized traffic
        for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 10, 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
